// File: rtl/vortex_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vortex_launch_ctrl
// Purpose  : Sequences one Vortex kernel launch. The core is held in reset,
//            its PC reset value is loaded, then reset is released and the
//            controller tracks vx_busy until the kernel ends. Sticky done and
//            error flags plus a launch cycle count feed the status registers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1          clock
//   reset            in   1          synchronous, active-high reset
//   start_req        in   1          one-cycle launch request (START reg write)
//   pc_reset_val_in  in   32         kernel entry PC, sampled on accepted start
//   done_clr         in   1          clears done / error flags
//   vx_busy          in   1          Vortex busy
//   vx_reset         out  1          Vortex reset (active-high)
//   vx_pc_reset_val  out  32         Vortex PC reset value (latched)
//   busy             out  1          launch in progress (state != IDLE)
//   done             out  1          sticky: kernel completed
//   err_no_busy      out  1          sticky: vx_busy never rose in time
//   err_timeout      out  1          sticky: watchdog expired in RUN
//   cycle_count      out  CNT_WIDTH  cycles spent in WAIT_BUSY + RUN
// ----------------------------------------------------------------------------
// Configuration macro
//   VX_LAUNCH_WATCHDOG_EN : when defined, a RUN-state watchdog aborts the
//                           launch after WATCHDOG_CYCLES cycles and raises
//                           err_timeout. When undefined, err_timeout is 0.
// ============================================================================
module vortex_launch_ctrl #(
  parameter int unsigned RESET_CYCLES           = 8,
  parameter int unsigned BUSY_WAIT_CYCLES       = 64,
  parameter logic [31:0] WATCHDOG_CYCLES        = 32'h0100_0000,
  parameter logic [31:0] PC_RESET_VAL_RESET_VAL = 32'hF000_0000,
  parameter int unsigned CNT_WIDTH              = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_req,
  input  logic [31:0]          pc_reset_val_in,
  input  logic                 done_clr,
  input  logic                 vx_busy,
  output logic                 vx_reset,
  output logic [31:0]          vx_pc_reset_val,
  output logic                 busy,
  output logic                 done,
  output logic                 err_no_busy,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned WAIT_W = (BUSY_WAIT_CYCLES > 1) ? $clog2(BUSY_WAIT_CYCLES) : 1;

  // Terminal values: counters start at 0 (wait) or at the top (hold), so the
  // exit compare sits on the last cycle of the respective window.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_HOLD = 3'd1,
    S_WAIT_BUSY  = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  // Remembers that DONE was entered through an error path so done stays low.
  logic                err_exit;

`ifdef VX_LAUNCH_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = WATCHDOG_CYCLES - 32'd1;
  logic [31:0]         run_cnt;
`else
  // Watchdog compiled out: the parameter is kept for a uniform interface.
  logic                unused_watchdog;
  assign unused_watchdog = ^WATCHDOG_CYCLES;
  assign err_timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      vx_reset        <= 1'b1;
      vx_pc_reset_val <= PC_RESET_VAL_RESET_VAL;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_no_busy     <= 1'b0;
      cycle_count     <= '0;
      hold_cnt        <= '0;
      wait_cnt        <= '0;
      err_exit        <= 1'b0;
`ifdef VX_LAUNCH_WATCHDOG_EN
      err_timeout     <= 1'b0;
      run_cnt         <= '0;
`endif
    end else begin
      // Clear first; any flag set later in this block overrides it, which
      // gives "set wins" when a flag event and done_clr coincide.
      if (done_clr) begin
        done        <= 1'b0;
        err_no_busy <= 1'b0;
`ifdef VX_LAUNCH_WATCHDOG_EN
        err_timeout <= 1'b0;
`endif
      end

      // Launch time covers WAIT_BUSY and RUN, saturating at all-ones.
      if ((state == S_WAIT_BUSY || state == S_RUN) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            state           <= S_RESET_HOLD;
            vx_pc_reset_val <= pc_reset_val_in;
            busy            <= 1'b1;
            vx_reset        <= 1'b1;
            done            <= 1'b0;
            err_no_busy     <= 1'b0;
            cycle_count     <= '0;
            hold_cnt        <= HOLD_LOAD;
            err_exit        <= 1'b0;
`ifdef VX_LAUNCH_WATCHDOG_EN
            err_timeout     <= 1'b0;
`endif
          end
        end

        S_RESET_HOLD: begin
          if (hold_cnt == '0) begin
            state    <= S_WAIT_BUSY;
            vx_reset <= 1'b0;
            wait_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        S_WAIT_BUSY: begin
          if (vx_busy) begin
            state <= S_RUN;
`ifdef VX_LAUNCH_WATCHDOG_EN
            run_cnt <= '0;
`endif
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= S_DONE;
            vx_reset    <= 1'b1;
            err_no_busy <= 1'b1;
            err_exit    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!vx_busy) begin
            state    <= S_DONE;
            vx_reset <= 1'b1;
          end
`ifdef VX_LAUNCH_WATCHDOG_EN
          else if (run_cnt == WD_LAST) begin
            // Stop a runaway kernel by putting the core back into reset.
            state       <= S_DONE;
            vx_reset    <= 1'b1;
            err_timeout <= 1'b1;
            err_exit    <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!err_exit) begin
            done <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          vx_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vortex_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vortex_launch_ctrl
// Purpose  : Directed, table-driven bench for vortex_launch_ctrl. Each table
//            row holds inputs applied for a number of clock edges and the
//            outputs expected afterwards; a few hand sequences cover the
//            start/done_clr overlap and the RUN watchdog behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vortex_launch_ctrl;

  localparam int unsigned RESET_CYCLES     = 4;
  localparam int unsigned BUSY_WAIT_CYCLES = 64;
  localparam logic [31:0] WATCHDOG_CYCLES  = 32'd100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_req;
  logic [31:0] pc_reset_val_in;
  logic        done_clr;
  logic        vx_busy;
  logic        vx_reset;
  logic [31:0] vx_pc_reset_val;
  logic        busy;
  logic        done;
  logic        err_no_busy;
  logic        err_timeout;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  vortex_launch_ctrl #(
    .RESET_CYCLES          (RESET_CYCLES),
    .BUSY_WAIT_CYCLES      (BUSY_WAIT_CYCLES),
    .WATCHDOG_CYCLES       (WATCHDOG_CYCLES),
    .PC_RESET_VAL_RESET_VAL(32'hF000_0000),
    .CNT_WIDTH             (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_req      (start_req),
    .pc_reset_val_in(pc_reset_val_in),
    .done_clr       (done_clr),
    .vx_busy        (vx_busy),
    .vx_reset       (vx_reset),
    .vx_pc_reset_val(vx_pc_reset_val),
    .busy           (busy),
    .done           (done),
    .err_no_busy    (err_no_busy),
    .err_timeout    (err_timeout),
    .cycle_count    (cycle_count)
  );

  typedef struct packed {
    logic        rst;
    logic        st;
    logic [31:0] pc;
    logic        clr;
    logic        vb;
    logic [7:0]  reps;
    logic        e_vxr;
    logic        e_busy;
    logic        e_done;
    logic        e_enb;
    logic        e_eto;
    logic [31:0] e_cc;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, input logic st, input logic [31:0] pc,
                     input logic clr, input logic vb, input logic [7:0] reps,
                     input logic e_vxr, input logic e_busy, input logic e_done,
                     input logic e_enb, input logic e_eto,
                     input logic [31:0] e_cc, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.st = st; v.pc = pc; v.clr = clr; v.vb = vb; v.reps = reps;
    v.e_vxr = e_vxr; v.e_busy = e_busy; v.e_done = e_done; v.e_enb = e_enb;
    v.e_eto = e_eto; v.e_cc = e_cc; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [31:0] p,
                       input logic c, input logic b);
    reset = r; start_req = s; pc_reset_val_in = p; done_clr = c; vx_busy = b;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_vxr, input logic e_busy,
                           input logic e_done, input logic e_enb, input logic e_eto,
                           input logic [31:0] e_cc, input logic [31:0] e_pc);
    chk({tag, ".vx_reset"},        {31'd0, vx_reset},    {31'd0, e_vxr});
    chk({tag, ".busy"},            {31'd0, busy},        {31'd0, e_busy});
    chk({tag, ".done"},            {31'd0, done},        {31'd0, e_done});
    chk({tag, ".err_no_busy"},     {31'd0, err_no_busy}, {31'd0, e_enb});
    chk({tag, ".err_timeout"},     {31'd0, err_timeout}, {31'd0, e_eto});
    chk({tag, ".cycle_count"},     cycle_count,          e_cc);
    chk({tag, ".vx_pc_reset_val"}, vx_pc_reset_val,      e_pc);
  endtask

  localparam logic [31:0] PC0 = 32'hF000_0000;
  localparam logic [31:0] PC1 = 32'hF000_0100;
  localparam logic [31:0] PC2 = 32'h0000_1000;
  localparam logic [31:0] PC3 = 32'hF000_0200;
  localparam logic [31:0] PC4 = 32'hF000_0300;

  initial begin
    //   rst st pc        clr vb reps  vxr bsy dn enb eto cc       pc_out
    // Reset state
    add(1, 0, 32'h0,  0, 0, 8'd2,  1, 0, 0, 0, 0, 32'd0,  PC0);
    // Nominal launch: 4 hold cycles, busy seen on 3rd WAIT edge, low on 20th RUN edge
    add(0, 1, PC1,    0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd0,  PC1);
    add(0, 0, 32'h0,  0, 0, 8'd3,  1, 1, 0, 0, 0, 32'd0,  PC1);
    add(0, 0, 32'h0,  0, 0, 8'd1,  0, 1, 0, 0, 0, 32'd0,  PC1);
    add(0, 0, 32'h0,  0, 0, 8'd2,  0, 1, 0, 0, 0, 32'd2,  PC1);
    add(0, 0, 32'h0,  0, 1, 8'd1,  0, 1, 0, 0, 0, 32'd3,  PC1);
    add(0, 0, 32'h0,  0, 1, 8'd19, 0, 1, 0, 0, 0, 32'd22, PC1);
    add(0, 0, 32'h0,  0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd23, PC1);
    add(0, 0, 32'h0,  0, 0, 8'd1,  1, 0, 1, 0, 0, 32'd23, PC1);
    add(0, 0, 32'h0,  1, 0, 8'd1,  1, 0, 0, 0, 0, 32'd23, PC1);
    add(0, 0, 32'h0,  0, 0, 8'd3,  1, 0, 0, 0, 0, 32'd23, PC1);
    // vx_busy never rises: error after 64 WAIT_BUSY cycles
    add(0, 1, PC2,    0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd0,  PC2);
    add(0, 0, 32'h0,  0, 0, 8'd4,  0, 1, 0, 0, 0, 32'd0,  PC2);
    add(0, 0, 32'h0,  0, 0, 8'd63, 0, 1, 0, 0, 0, 32'd63, PC2);
    add(0, 0, 32'h0,  0, 0, 8'd1,  1, 1, 0, 1, 0, 32'd64, PC2);
    add(0, 0, 32'h0,  0, 0, 8'd1,  1, 0, 0, 1, 0, 32'd64, PC2);
    add(0, 0, 32'h0,  1, 0, 8'd1,  1, 0, 0, 0, 0, 32'd64, PC2);
    // start_req during RUN ignored; done_clr during DONE loses to the set
    add(0, 1, PC3,    0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd0,  PC3);
    add(0, 0, 32'h0,  0, 0, 8'd4,  0, 1, 0, 0, 0, 32'd0,  PC3);
    add(0, 0, 32'h0,  0, 1, 8'd1,  0, 1, 0, 0, 0, 32'd1,  PC3);
    add(0, 1, 32'h8000_0000, 0, 1, 8'd1, 0, 1, 0, 0, 0, 32'd2, PC3);
    add(0, 0, 32'h0,  0, 1, 8'd5,  0, 1, 0, 0, 0, 32'd7,  PC3);
    add(0, 0, 32'h0,  0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd8,  PC3);
    add(0, 0, 32'h0,  1, 0, 8'd1,  1, 0, 1, 0, 0, 32'd8,  PC3);
    add(0, 0, 32'h0,  1, 0, 8'd1,  1, 0, 0, 0, 0, 32'd8,  PC3);
    // reset asserted in RUN abandons the launch
    add(0, 1, PC4,    0, 0, 8'd1,  1, 1, 0, 0, 0, 32'd0,  PC4);
    add(0, 0, 32'h0,  0, 0, 8'd4,  0, 1, 0, 0, 0, 32'd0,  PC4);
    add(0, 0, 32'h0,  0, 1, 8'd3,  0, 1, 0, 0, 0, 32'd3,  PC4);
    add(0, 0, 32'h0,  0, 1, 8'd2,  0, 1, 0, 0, 0, 32'd5,  PC4);
    add(1, 0, 32'h0,  0, 1, 8'd1,  1, 0, 0, 0, 0, 32'd0,  PC0);
    add(0, 0, 32'h0,  0, 0, 8'd3,  1, 0, 0, 0, 0, 32'd0,  PC0);

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].pc, tbl[i].clr, tbl[i].vb);
      step(int'(tbl[i].reps));
      check_all($sformatf("v%0d", i), tbl[i].e_vxr, tbl[i].e_busy, tbl[i].e_done,
                tbl[i].e_enb, tbl[i].e_eto, tbl[i].e_cc, tbl[i].e_pc);
    end

    // Short launch, then start_req together with done_clr: the start is taken.
    drive(0, 1, 32'hF000_0400, 0, 0); step(1);
    drive(0, 0, 32'h0, 0, 0);         step(4);
    drive(0, 0, 32'h0, 0, 1);         step(1);
    drive(0, 0, 32'h0, 0, 0);         step(2);
    check_all("short_done", 1, 0, 1, 0, 0, 32'd2, 32'hF000_0400);
    drive(0, 1, 32'hF000_0500, 1, 0); step(1);
    check_all("start_wins", 1, 1, 0, 0, 0, 32'd0, 32'hF000_0500);
    drive(0, 0, 32'h0, 0, 0);         step(4);
    drive(0, 0, 32'h0, 0, 1);         step(1);
    drive(0, 0, 32'h0, 0, 0);         step(2);
    check_all("second_done", 1, 0, 1, 0, 0, 32'd2, 32'hF000_0500);
    drive(0, 0, 32'h0, 1, 0);         step(1);

    // Long RUN with vx_busy stuck high.
    drive(0, 1, PC1, 0, 0);           step(1);
    drive(0, 0, 32'h0, 0, 0);         step(4);
    drive(0, 0, 32'h0, 0, 1);         step(1);
    step(99);
    check_all("run_99", 0, 1, 0, 0, 0, 32'd100, PC1);
`ifdef VX_LAUNCH_WATCHDOG_EN
    step(1);
    check_all("wd_expire", 1, 1, 0, 0, 1, 32'd101, PC1);
    step(1);
    check_all("wd_idle", 1, 0, 0, 0, 1, 32'd101, PC1);
    drive(0, 0, 32'h0, 1, 1);         step(1);
    check_all("wd_clr", 1, 0, 0, 0, 0, 32'd101, PC1);
`else
    step(51);
    check_all("run_150", 0, 1, 0, 0, 0, 32'd151, PC1);
    drive(0, 0, 32'h0, 0, 0);         step(2);
    check_all("run_end", 1, 0, 1, 0, 0, 32'd152, PC1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
